// File: rtl/wordcopy_stream.sv
// Avalon-MM word copy / fill engine: pipelined SRC reads feed a FIFO drained by DST writes.
// A 32-bit CPU register slave programs the job; one master port talks to SDRAM.
module wordcopy_stream #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_OUTST  = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              slave_waitrequest,
    input  logic [3:0]        slave_address,
    input  logic              slave_read,
    output logic [31:0]       slave_readdata,
    input  logic              slave_write,
    input  logic [31:0]       slave_writedata,
    input  logic              master_waitrequest,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid,
    output logic              master_write,
    output logic [DATA_W-1:0] master_writedata,
    output logic              irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CAP   = (FIFO_DEPTH < MAX_OUTST) ? FIFO_DEPTH : MAX_OUTST;
    localparam logic [CNT_W:0]    CAP_V = (CNT_W+1)'(CAP);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(DATA_W/8);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t            state_q;
    logic [31:0]       dst_q, src_q, count_q, fill_q, progress_q;
    logic              mode_q, irq_en_q, done_q;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q, master_address_q;
    logic [31:0]       reads_left_q, writes_left_q;
    logic [CNT_W-1:0]  inflight_q, fifo_cnt_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic              master_read_q, master_write_q;
    logic [DATA_W-1:0] master_writedata_q;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    logic             busy, rd_acc, wr_acc, push, pop, req_idle, can_read;
    logic             start, cfg_wr;
    logic [CNT_W:0]   occ;
    logic [CNT_W-1:0] inflight_d, fifo_cnt_d;

    assign busy     = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign rd_acc   = master_read_q && !master_waitrequest;
    assign wr_acc   = master_write_q && !master_waitrequest;
    // Data beats with nothing outstanding (stray or post-reset) are discarded.
    assign push     = master_readdatavalid && (inflight_q != '0);
    assign pop      = wr_acc && !mode_q;
    assign req_idle = !master_read_q && !master_write_q;
    assign occ      = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    assign can_read = (state_q == S_RUN) && !mode_q && (reads_left_q != 32'd0) && (occ < CAP_V);

    assign inflight_d = inflight_q + CNT_W'(rd_acc) - CNT_W'(push);
    assign fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

    assign start  = slave_write && (slave_address == 4'd0) && slave_writedata[0] && !busy;
    assign cfg_wr = slave_write && !busy;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= master_readdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= S_IDLE;
            dst_q              <= '0;
            src_q              <= '0;
            count_q            <= '0;
            fill_q             <= '0;
            progress_q         <= '0;
            mode_q             <= 1'b0;
            irq_en_q           <= 1'b0;
            done_q             <= 1'b0;
            rd_addr_q          <= '0;
            wr_addr_q          <= '0;
            reads_left_q       <= '0;
            writes_left_q      <= '0;
            inflight_q         <= '0;
            fifo_cnt_q         <= '0;
            wr_ptr_q           <= '0;
            rd_ptr_q           <= '0;
            master_read_q      <= 1'b0;
            master_write_q     <= 1'b0;
            master_address_q   <= '0;
            master_writedata_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (push)   wr_ptr_q   <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q   <= rd_ptr_q + 1'b1;
            if (wr_acc) progress_q <= progress_q + 32'd1;

            if (cfg_wr) begin
                case (slave_address)
                    4'd0: irq_en_q <= slave_writedata[2];
                    4'd1: dst_q    <= slave_writedata;
                    4'd2: src_q    <= slave_writedata;
                    4'd3: count_q  <= slave_writedata;
                    4'd4: fill_q   <= slave_writedata;
                    default: ;
                endcase
            end
            if (slave_write && (slave_address == 4'd0) && slave_writedata[3]) done_q <= 1'b0;

            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (start) begin
                        mode_q        <= slave_writedata[1];
                        done_q        <= (count_q == 32'd0);
                        progress_q    <= '0;
                        rd_addr_q     <= ADDR_W'(src_q);
                        wr_addr_q     <= ADDR_W'(dst_q);
                        reads_left_q  <= count_q;
                        writes_left_q <= count_q;
                        state_q       <= (count_q == 32'd0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN, S_FLUSH: begin
                    if (rd_acc) begin
                        master_read_q <= 1'b0;
                        rd_addr_q     <= rd_addr_q + STEP;
                        reads_left_q  <= reads_left_q - 32'd1;
                        if (reads_left_q == 32'd1) state_q <= S_FLUSH;
                    end
                    if (wr_acc) begin
                        master_write_q <= 1'b0;
                        wr_addr_q      <= wr_addr_q + STEP;
                        writes_left_q  <= writes_left_q - 32'd1;
                        // The Nth accepted write implies every read returned and the FIFO is empty.
                        if (writes_left_q == 32'd1) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    if (req_idle) begin
                        if (mode_q) begin
                            if (writes_left_q != 32'd0) begin
                                master_write_q     <= 1'b1;
                                master_address_q   <= wr_addr_q;
                                master_writedata_q <= {(DATA_W/32){fill_q}};
                            end
                        end else if (can_read) begin
                            master_read_q    <= 1'b1;
                            master_address_q <= rd_addr_q;
                        end else if (fifo_cnt_q != '0) begin
                            master_write_q     <= 1'b1;
                            master_address_q   <= wr_addr_q;
                            master_writedata_q <= fifo_mem[rd_ptr_q];
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        slave_readdata = 32'd0;
        case (slave_address)
            4'd0: slave_readdata = {28'd0, irq_en_q, mode_q, done_q, busy};
            4'd1: slave_readdata = dst_q;
            4'd2: slave_readdata = src_q;
            4'd3: slave_readdata = count_q;
            4'd4: slave_readdata = fill_q;
            4'd5: slave_readdata = progress_q;
            default: slave_readdata = 32'd0;
        endcase
    end

    // Only a STATUS read stalls, so the CPU can block on job completion.
    assign slave_waitrequest = slave_read && (slave_address == 4'd0) && busy;
    assign master_read       = master_read_q;
    assign master_write      = master_write_q;
    assign master_address    = master_address_q;
    assign master_writedata  = master_writedata_q;
    assign irq               = done_q & irq_en_q;
endmodule

// File: tb/tb_wordcopy_stream.sv
// Directed bench for wordcopy_stream: CPU register driver plus a pipelined SDRAM model
// with configurable read latency and optional random waitrequest.
module tb_wordcopy_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        slave_waitrequest;
    logic [3:0]  slave_address = '0;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = '0;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata = '0;
    logic        master_readdatavalid = 1'b0;
    logic        master_write;
    logic [31:0] master_writedata;
    logic        irq;

    wordcopy_stream #(.DATA_W(32), .ADDR_W(32), .FIFO_DEPTH(8), .MAX_OUTST(4)) dut (
        .clk(clk), .rst(rst),
        .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
        .slave_read(slave_read), .slave_readdata(slave_readdata),
        .slave_write(slave_write), .slave_writedata(slave_writedata),
        .master_waitrequest(master_waitrequest), .master_address(master_address),
        .master_read(master_read), .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid), .master_write(master_write),
        .master_writedata(master_writedata), .irq(irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [1024];
    typedef struct { logic [31:0] data; int due; } rd_t;
    rd_t         rdq[$];
    logic [31:0] wlog[$];
    int  cyc = 0, lat = 1;
    bit  rand_wait = 1'b0;
    int  reads_seen = 0, writes_seen = 0, outst = 0, max_outst = 0;
    int  overlap_err = 0, hold_err = 0;
    bit  held = 1'b0;
    logic        h_rd, h_wr;
    logic [31:0] h_addr, h_data;

    // SDRAM model: samples requests at the edge, drives its inputs 1 time unit later.
    always @(posedge clk) begin
        cyc++;
        if (master_readdatavalid && outst > 0) outst--;
        if (master_read && master_write) overlap_err++;
        if (held && (master_read !== h_rd || master_write !== h_wr ||
                     master_address !== h_addr || master_writedata !== h_data)) hold_err++;
        held   = (master_read || master_write) && master_waitrequest;
        h_rd   = master_read;
        h_wr   = master_write;
        h_addr = master_address;
        h_data = master_writedata;
        if (master_read && !master_waitrequest) begin
            rdq.push_back('{mem[master_address[11:2]], cyc + lat});
            reads_seen++;
            outst++;
            if (outst > max_outst) max_outst = outst;
        end
        if (master_write && !master_waitrequest) begin
            mem[master_address[11:2]] = master_writedata;
            writes_seen++;
            wlog.push_back(master_address);
        end
        #1;
        master_waitrequest = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
        if (rdq.size() > 0 && rdq[0].due <= cyc + 1) begin
            master_readdatavalid = 1'b1;
            master_readdata      = rdq[0].data;
            rdq.delete(0);
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata      = '0;
        end
    end

    task automatic clear_stats();
        reads_seen = 0; writes_seen = 0; max_outst = 0;
        overlap_err = 0; hold_err = 0;
        wlog.delete();
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_address = a; slave_writedata = d; slave_write = 1'b1;
        @(posedge clk); #1;
        slave_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d, output int w);
        @(negedge clk);
        slave_address = a; slave_read = 1'b1; w = 0;
        #1;
        while (slave_waitrequest === 1'b1 && w < 500) begin
            @(negedge clk); #1;
            w++;
        end
        d = (w >= 500) ? 32'hxxxxxxxx : slave_readdata;
        @(posedge clk); #1;
        slave_read = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; int w;
        tests++; if (master_read !== 1'b0 || master_write !== 1'b0) begin fails++;
            $display("FAIL reset_rw got rd=%b wr=%b exp 0 0", master_read, master_write); end
        tests++; if (master_address !== 32'h0 || master_writedata !== 32'h0) begin fails++;
            $display("FAIL reset_addr_data got %h %h exp 0 0", master_address, master_writedata); end
        tests++; if (irq !== 1'b0 || slave_waitrequest !== 1'b0) begin fails++;
            $display("FAIL reset_irq_wait got %b %b exp 0 0", irq, slave_waitrequest); end
        cpu_read(4'd0, d, w);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_status got %h exp 0", d); end
        cpu_read(4'd3, d, w);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_count got %h exp 0", d); end
        cpu_read(4'd9, d, w);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL unmapped_read got %h exp 0", d); end
    endtask

    task automatic test_copy_basic();
        logic [31:0] d; int w;
        clear_stats(); lat = 1; rand_wait = 1'b0;
        cpu_write(4'd2, 32'h100); cpu_write(4'd1, 32'h200); cpu_write(4'd3, 32'd4);
        cpu_write(4'd0, 32'h1);
        cpu_read(4'd0, d, w);
        tests++; if (d !== 32'h2) begin fails++; $display("FAIL copy_status got %h exp 2", d); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL copy_irq_off got %b exp 0", irq); end
        cpu_read(4'd5, d, w);
        tests++; if (d !== 32'd4) begin fails++; $display("FAIL copy_progress got %0d exp 4", d); end
        tests++; if (reads_seen != 4 || writes_seen != 4) begin fails++;
            $display("FAIL copy_counts got r=%0d w=%0d exp 4 4", reads_seen, writes_seen); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (mem[10'h80 + i] !== 32'hC0DE0040 + i) begin fails++;
                $display("FAIL copy_data[%0d] got %h exp %h", i, mem[10'h80 + i], 32'hC0DE0040 + i); end
        end
        tests++; if (wlog.size() != 4 || wlog[0] !== 32'h200 || wlog[3] !== 32'h20C) begin fails++;
            $display("FAIL copy_waddr got n=%0d exp 4 writes 0x200..0x20C", wlog.size()); end
    endtask

    task automatic test_zero_count();
        logic [31:0] d; int w;
        clear_stats();
        cpu_write(4'd3, 32'd0); cpu_write(4'd0, 32'h1);
        cpu_read(4'd0, d, w);
        tests++; if (d !== 32'h2 || w != 0) begin fails++;
            $display("FAIL zero_status got %h waits=%0d exp 2 waits=0", d, w); end
        repeat (5) @(negedge clk);
        tests++; if (reads_seen != 0 || writes_seen != 0) begin fails++;
            $display("FAIL zero_traffic got r=%0d w=%0d exp 0 0", reads_seen, writes_seen); end
        cpu_read(4'd5, d, w);
        tests++; if (d !== 32'd0) begin fails++; $display("FAIL zero_progress got %0d exp 0", d); end
    endtask

    task automatic test_fill();
        logic [31:0] d; int w;
        clear_stats();
        cpu_write(4'd1, 32'h40); cpu_write(4'd3, 32'd3); cpu_write(4'd4, 32'hDEADBEEF);
        cpu_write(4'd0, 32'h3);
        cpu_read(4'd0, d, w);
        tests++; if (d !== 32'h6) begin fails++; $display("FAIL fill_status got %h exp 6", d); end
        tests++; if (reads_seen != 0 || writes_seen != 3) begin fails++;
            $display("FAIL fill_counts got r=%0d w=%0d exp 0 3", reads_seen, writes_seen); end
        for (int i = 0; i < 3; i++) begin
            tests++; if (mem[10'h10 + i] !== 32'hDEADBEEF) begin fails++;
                $display("FAIL fill_data[%0d] got %h exp DEADBEEF", i, mem[10'h10 + i]); end
        end
        tests++; if (mem[10'h13] !== 32'hC0DE0013) begin fails++;
            $display("FAIL fill_overrun got %h exp C0DE0013", mem[10'h13]); end
        tests++; if (wlog.size() != 3 || wlog[0] !== 32'h40 || wlog[1] !== 32'h44 || wlog[2] !== 32'h48) begin
            fails++; $display("FAIL fill_waddr got n=%0d exp 0x40,0x44,0x48", wlog.size()); end
        cpu_read(4'd5, d, w);
        tests++; if (d !== 32'd3) begin fails++; $display("FAIL fill_progress got %0d exp 3", d); end
    endtask

    task automatic test_status_block_irq();
        logic [31:0] d; int w;
        clear_stats(); lat = 3; rand_wait = 1'b1;
        cpu_write(4'd1, 32'h380); cpu_write(4'd2, 32'h300); cpu_write(4'd3, 32'd8);
        cpu_write(4'd0, 32'h5);
        cpu_write(4'd1, 32'h999);
        cpu_read(4'd0, d, w);
        tests++; if (d !== 32'hA) begin fails++; $display("FAIL blk_status got %h exp A", d); end
        tests++; if (w == 0) begin fails++; $display("FAIL blk_waits got %0d exp >0", w); end
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL blk_irq got %b exp 1", irq); end
        cpu_read(4'd1, d, w);
        tests++; if (d !== 32'h380) begin fails++; $display("FAIL busy_dst_locked got %h exp 380", d); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (mem[10'hE0 + i] !== 32'hC0DE00C0 + i) begin fails++;
                $display("FAIL blk_data[%0d] got %h exp %h", i, mem[10'hE0 + i], 32'hC0DE00C0 + i); end
        end
        tests++; if (hold_err != 0) begin fails++; $display("FAIL blk_hold got %0d exp 0", hold_err); end
        cpu_write(4'd0, 32'hC);
        cpu_read(4'd0, d, w);
        tests++; if (d !== 32'h8 || irq !== 1'b0) begin fails++;
            $display("FAIL ack_status got %h irq=%b exp 8 irq=0", d, irq); end
    endtask

    task automatic test_long_random();
        logic [31:0] d; int w;
        clear_stats(); lat = 7; rand_wait = 1'b1;
        cpu_write(4'd2, 32'h400); cpu_write(4'd1, 32'h800); cpu_write(4'd3, 32'd16);
        cpu_write(4'd0, 32'h1);
        cpu_read(4'd0, d, w);
        rand_wait = 1'b0;
        tests++; if (d !== 32'h2) begin fails++; $display("FAIL long_status got %h exp 2", d); end
        tests++; if (max_outst > 4 || max_outst < 2) begin fails++;
            $display("FAIL long_inflight got %0d exp 2..4", max_outst); end
        tests++; if (hold_err != 0 || overlap_err != 0) begin fails++;
            $display("FAIL long_protocol got hold=%0d overlap=%0d exp 0 0", hold_err, overlap_err); end
        tests++; if (reads_seen != 16 || writes_seen != 16) begin fails++;
            $display("FAIL long_counts got r=%0d w=%0d exp 16 16", reads_seen, writes_seen); end
        for (int i = 0; i < 16; i++) begin
            tests++; if (mem[10'h200 + i] !== 32'hC0DE0100 + i) begin fails++;
                $display("FAIL long_data[%0d] got %h exp %h", i, mem[10'h200 + i], 32'hC0DE0100 + i); end
        end
        cpu_read(4'd5, d, w);
        tests++; if (d !== 32'd16) begin fails++; $display("FAIL long_progress got %0d exp 16", d); end
    endtask

    task automatic test_reset_midjob();
        logic [31:0] d; int w; int t;
        clear_stats(); lat = 7; rand_wait = 1'b0;
        cpu_write(4'd2, 32'h500); cpu_write(4'd1, 32'h600); cpu_write(4'd3, 32'd8);
        cpu_write(4'd0, 32'h1);
        t = 0;
        while (outst < 3 && t < 200) begin @(negedge clk); t++; end
        tests++; if (t >= 200) begin fails++; $display("FAIL mid_inflight3 got timeout exp 3 in flight"); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        tests++; if (master_read !== 1'b0 || master_write !== 1'b0 || master_address !== 32'h0) begin
            fails++; $display("FAIL mid_rst_outputs got rd=%b wr=%b a=%h exp 0 0 0",
                              master_read, master_write, master_address); end
        @(negedge clk); rst = 1'b0;
        writes_seen = 0; reads_seen = 0;
        repeat (20) @(negedge clk);
        tests++; if (writes_seen != 0 || reads_seen != 0) begin fails++;
            $display("FAIL mid_quiet got r=%0d w=%0d exp 0 0", reads_seen, writes_seen); end
        cpu_read(4'd0, d, w);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL mid_status got %h exp 0", d); end
        clear_stats(); lat = 1;
        cpu_write(4'd2, 32'h100); cpu_write(4'd1, 32'h700); cpu_write(4'd3, 32'd4);
        cpu_write(4'd0, 32'h1);
        cpu_read(4'd0, d, w);
        tests++; if (d !== 32'h2 || writes_seen != 4) begin fails++;
            $display("FAIL mid_newjob got st=%h w=%0d exp 2 4", d, writes_seen); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (mem[10'h1C0 + i] !== 32'hC0DE0040 + i) begin fails++;
                $display("FAIL mid_data[%0d] got %h exp %h", i, mem[10'h1C0 + i], 32'hC0DE0040 + i); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 + i;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_copy_basic();
        test_zero_count();
        test_fill();
        test_status_block_irq();
        test_long_random();
        test_reset_midjob();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
